// File: rtl/bridge_resp_pkg.sv
// Shared types and constants for the bridge memory responder.
// State and response-kind encodings plus the error read pattern.
// Imported by bridge_mem_responder.
package bridge_resp_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    TAS_WR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    STORE = 2'd1,
    ERR   = 2'd2
  } resp_kind_e;

  localparam logic [31:0] BRIDGE_ERR_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/bridge_mem_responder.sv
// Bridge request endpoint driving a 1-cycle-latency single-port SRAM.
// Latency: response one cycle after grant; TAS blocks grant for one extra cycle.
// Backpressure: grant drops only during the TAS write cycle; responses are never stalled.
module bridge_mem_responder
  import bridge_resp_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int AUX_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_req_i,
  input  logic                      data_ts_set_i,
  input  logic [ADDR_WIDTH-1:0]     data_add_i,
  input  logic                      data_wen_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [BE_WIDTH-1:0]       data_be_i,
  input  logic [ID_WIDTH-1:0]       data_ID_i,
  input  logic [AUX_WIDTH-1:0]      data_aux_i,
  output logic                      data_gnt_o,
  output logic                      data_r_valid_o,
  output logic [ID_WIDTH-1:0]       data_r_ID_o,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
  output logic [AUX_WIDTH-1:0]      data_r_aux_o,
  output logic                      data_r_opc_o,
  output logic                      mem_req_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int OFF = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 0;
  localparam int WHI = MEM_ADDR_WIDTH + OFF;
  // Address bits above the word field; any of them set means out of range.
  localparam logic [ADDR_WIDTH-1:0] HI_MASK =
    ~((ADDR_WIDTH'(1) << WHI) - ADDR_WIDTH'(1));
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(BRIDGE_ERR_RDATA);

  state_e                    state_q;
  logic [MEM_ADDR_WIDTH-1:0] tas_add_q;

  logic                      rvalid_q;
  logic [ID_WIDTH-1:0]       rid_q;
  logic [AUX_WIDTH-1:0]      raux_q;
  logic                      ropc_q;
  resp_kind_e                rkind_q;
  logic [DATA_WIDTH-1:0]     rdata_q;

  logic [MEM_ADDR_WIDTH-1:0] word_add;
  logic                      out_of_range;
  logic                      fire;
  logic                      tas_start;

  assign word_add     = data_add_i[WHI-1:OFF];
  assign out_of_range = |(data_add_i & HI_MASK);

  // Grant depends on state only, so the requester never sees a req->gnt loop.
  assign data_gnt_o = rst_n & (state_q == IDLE);
  assign fire       = data_req_i & data_gnt_o;
  assign tas_start  = fire & ~out_of_range & data_ts_set_i & data_wen_i;

  // SRAM port: TAS write-back cycle has priority, otherwise pass the granted request through.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (state_q == TAS_WR) begin
      mem_req_o   = 1'b1;
      mem_wen_o   = 1'b0;
      mem_add_o   = tas_add_q;
      mem_wdata_o = '1;
      mem_be_o    = '1;
    end else if (fire && !out_of_range) begin
      mem_req_o   = 1'b1;
      mem_wen_o   = data_wen_i;
      mem_add_o   = word_add;
      mem_wdata_o = data_wdata_i;
      mem_be_o    = data_be_i;
    end
  end

  // TAS sequencer: hold the word address for the all-ones write in the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tas_add_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tas_start) begin
            state_q   <= TAS_WR;
            tas_add_q <= word_add;
          end
        end
        TAS_WR:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response stage: capture ID/aux/kind of whatever was granted this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      raux_q   <= '0;
      ropc_q   <= 1'b0;
      rkind_q  <= STORE;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= fire;
      rid_q    <= fire ? data_ID_i  : '0;
      raux_q   <= fire ? data_aux_i : '0;
      ropc_q   <= fire & out_of_range;
      rkind_q  <= out_of_range ? ERR : (data_wen_i ? LOAD : STORE);
      rdata_q  <= (fire && out_of_range) ? ERR_RDATA : '0;
    end
  end

  assign data_r_valid_o = rvalid_q;
  assign data_r_ID_o    = rid_q;
  assign data_r_aux_o   = raux_q;
  assign data_r_opc_o   = ropc_q;
  // Load data comes straight from the SRAM in the response cycle.
  assign data_r_rdata_o = (rvalid_q && rkind_q == LOAD) ? mem_rdata_i : rdata_q;

endmodule

// File: doc/bridge_mem_responder.md
# bridge_mem_responder

Target-side endpoint of the single-port bridge request channel. Accepts the arbitrated bridge port (req/gnt plus address, write enable, data, byte enable, ID, aux, test-and-set flag) and drives a single-port SRAM with one-cycle read latency. Returns a fixed-latency response (r_valid, r_ID, r_rdata, r_aux, r_opc) back toward the response decoder. Executes test-and-set as an atomic read-then-write-all-ones sequence and flags out-of-range accesses without touching memory.

## Interface
- ADDR_WIDTH, 32, byte address width of the bridge port
- ID_WIDTH, 16, request/response ID width
- DATA_WIDTH, 32, data word width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- AUX_WIDTH, 32, sideband width, echoed in response
- MEM_ADDR_WIDTH, 10, SRAM word-address width

Ports (clock and reset first):
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- data_req_i  in  1  request valid
- data_ts_set_i  in  1  request is test-and-set
- data_add_i  in  ADDR_WIDTH  byte address
- data_wen_i  in  1  1 = load, 0 = store
- data_wdata_i  in  DATA_WIDTH  store data
- data_be_i  in  BE_WIDTH  byte enables
- data_ID_i  in  ID_WIDTH  request ID
- data_aux_i  in  AUX_WIDTH  sideband
- data_gnt_o  out  1  grant
- data_r_valid_o  out  1  response valid
- data_r_ID_o  out  ID_WIDTH  response ID
- data_r_rdata_o  out  DATA_WIDTH  read data
- data_r_aux_o  out  AUX_WIDTH  echoed sideband
- data_r_opc_o  out  1  1 = out-of-range error
- mem_req_o  out  1  SRAM chip enable
- mem_wen_o  out  1  1 = read, 0 = write
- mem_add_o  out  MEM_ADDR_WIDTH  SRAM word address
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_be_o  out  BE_WIDTH  SRAM byte enables
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after read

## Operation
- Handshake: transfer occurs when data_req_i && data_gnt_o on a rising edge. data_gnt_o = rst_n && state==IDLE (combinational from state only, never from req).
- Word address = data_add_i[MEM_ADDR_WIDTH+log2(BE_WIDTH)-1 : log2(BE_WIDTH)]; low log2(BE_WIDTH) bits ignored.
- Out-of-range: any data_add_i bit above the word field set -> mem_req_o=0, response opc=1, rdata=32'hBADACCE5 (truncated/zero-extended to DATA_WIDTH), no state change.
- Plain load/store: mem_req_o=1, memory fields passed straight through in the grant cycle.
- data_ts_set_i with data_wen_i=0 (store): ignored, treated as plain store.
- Test-and-set load: grant cycle issues read; FSM IDLE -> TAS_WR. In TAS_WR: gnt=0, mem_req_o=1, mem_wen_o=0, same word address (registered), mem_wdata_o all ones, mem_be_o all ones; return to IDLE next edge.
- FSM states: IDLE, TAS_WR. Only transition out of IDLE is an in-range granted TAS load.
- Every granted request (load, store, error, TAS) produces exactly one response; stores return r_rdata=0. The TAS internal write produces none.

## Timing
- Reset: all outputs 0 (data_gnt_o 0 while rst_n low), state IDLE, response registers cleared. Reset mid-TAS abandons the pending write.
- Response latency: granted at edge T -> data_r_valid_o high for exactly one cycle after edge T; r_ID/r_aux/r_opc registered at T; r_rdata = mem_rdata_i (load) muxed combinationally in that cycle, or registered constant for error/store.
- TAS: read edge T, write edge T+1, response (old data) in cycle after T, next grant possible at edge T+2.
- Throughput: one request per cycle, back-to-back, no response backpressure.
- Simultaneous response and new grant are normal; response registers update every cycle.

## Structure
- Package bridge_resp_pkg: state enum (IDLE, TAS_WR), error pattern constant BRIDGE_ERR_RDATA, response-kind enum (LOAD, STORE, ERR).
- Single module, no sub-module: FSM, address decode/range check, response register stage.

## Test plan
- Store 0xDEADBEEF BE=4'hF to 0x10, then load 0x10 ID=3 -> store response rdata=0, load response one cycle after grant with rdata=0xDEADBEEF, r_ID=3.
- Back-to-back loads to 0x0,0x4,0x8 every cycle -> gnt held 1, three consecutive r_valid cycles with IDs in order.
- TAS load to 0x20 holding 0x5 -> response rdata=0x5, gnt low one cycle, following load of 0x20 returns 0xFFFFFFFF.
- Load address with bit MEM_ADDR_WIDTH+2 set, aux=0xA5 -> mem_req_o stays 0, r_opc=1, rdata=0xBADACCE5, r_aux=0xA5.
- Assert rst_n low during TAS_WR -> no SRAM write occurs, all outputs 0, gnt returns 1 the cycle after release.
